// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode values, FSM states, control bundle and
// the opcode-level helpers used by the decode stage.
package decode_pkg;

    localparam int OPCODE_W = 5;
    localparam int RIDX_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_POP  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_PUSH = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_LDM  = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_IADD = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_LDD  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_STD  = 5'b11011;

    // S_OP: expecting an opcode word; S_IMM: expecting the immediate word
    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Any opcode with both top bits set carries a trailing immediate word
    function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
        return (opcode[4:3] == 2'b11);
    endfunction

    // Control bits per opcode; unlisted opcodes behave as NOP
    function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] opcode);
        ctrl_t c;
        c = '0;
        if (opcode[4] == 1'b0) begin
            // 00001..01111 are register-to-register ALU operations
            c.reg_write = (opcode != OP_NOP);
        end else begin
            case (opcode)
                OP_POP:  begin c.mem_read = 1'b1; c.reg_write = 1'b1; end
                OP_PUSH: c.mem_write = 1'b1;
                OP_LDM:  c.reg_write = 1'b1;
                OP_IADD: c.reg_write = 1'b1;
                OP_LDD:  begin c.mem_read = 1'b1; c.reg_write = 1'b1; end
                OP_STD:  c.mem_write = 1'b1;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file: NREGS x DATA_W, two combinational read ports, one
// synchronous write port with write-through bypass, async active-low clear.
module reg_file
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] reg_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;

            // One storage word per register, written when addressed
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    q_reg <= wr_data;
                end
            end

            assign reg_q[gi] = q_reg;
        end
    endgenerate

    // Same-cycle write data wins over the stored value
    assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : reg_q[rd_addr_a];
    assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : reg_q[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits the fetched word, reads the register file, assembles
// two-word immediate instructions and stalls fetch on load-use hazards.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction_r,
    input  logic [PC_W-1:0]   pc_plus_one_r,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [4:0]        id_ex_opcode,
    output logic [2:0]        id_ex_rdst,
    output logic [2:0]        id_ex_rsrc1,
    output logic [2:0]        id_ex_rsrc2,
    output logic [DATA_W-1:0] id_ex_rs1_data,
    output logic [DATA_W-1:0] id_ex_rs2_data,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [PC_W-1:0]   id_ex_pc_plus_one,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write
);

    // Fields of the word currently presented by fetch; bits [1:0] carry nothing
    logic [4:0] cur_opcode;
    logic [2:0] cur_rdst;
    logic [2:0] cur_rsrc1;
    logic [2:0] cur_rsrc2;
    logic [1:0] unused_low_bits;

    assign cur_opcode      = instruction_r[15:11];
    assign cur_rdst        = instruction_r[10:8];
    assign cur_rsrc1       = instruction_r[7:5];
    assign cur_rsrc2       = instruction_r[4:2];
    assign unused_low_bits = instruction_r[1:0];

    state_t state_reg, state_next;

    // First word of a two-word instruction, kept while the immediate arrives
    logic [4:0]      hold_opcode_reg, hold_opcode_next;
    logic [2:0]      hold_rdst_reg,   hold_rdst_next;
    logic [2:0]      hold_rsrc1_reg,  hold_rsrc1_next;
    logic [2:0]      hold_rsrc2_reg,  hold_rsrc2_next;
    logic [PC_W-1:0] hold_pc_reg,     hold_pc_next;

    // ID/EX pipeline register
    logic              ex_valid_reg,     ex_valid_next;
    logic [4:0]        ex_opcode_reg,    ex_opcode_next;
    logic [2:0]        ex_rdst_reg,      ex_rdst_next;
    logic [2:0]        ex_rsrc1_reg,     ex_rsrc1_next;
    logic [2:0]        ex_rsrc2_reg,     ex_rsrc2_next;
    logic [DATA_W-1:0] ex_rs1_data_reg,  ex_rs1_data_next;
    logic [DATA_W-1:0] ex_rs2_data_reg,  ex_rs2_data_next;
    logic [DATA_W-1:0] ex_imm_reg,       ex_imm_next;
    logic [PC_W-1:0]   ex_pc_reg,        ex_pc_next;
    logic              ex_reg_write_reg, ex_reg_write_next;
    logic              ex_mem_read_reg,  ex_mem_read_next;
    logic              ex_mem_write_reg, ex_mem_write_next;

    // Register file read side: held indices while the immediate is consumed
    logic [2:0]        rd_idx_a, rd_idx_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;

    assign rd_idx_a = (state_reg == S_IMM) ? hold_rsrc1_reg : cur_rsrc1;
    assign rd_idx_b = (state_reg == S_IMM) ? hold_rsrc2_reg : cur_rsrc2;

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (3)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (rd_idx_a),
        .rd_addr_b (rd_idx_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    ctrl_t cur_ctrl, hold_ctrl;
    assign cur_ctrl  = decode_ctrl(cur_opcode);
    assign hold_ctrl = decode_ctrl(hold_opcode_reg);

    // Load-use check is deliberately conservative: both source fields are
    // compared even for opcodes that do not read them.
    logic hazard;
    assign hazard = (state_reg == S_OP) && ex_valid_reg && ex_mem_read_reg &&
                    ((ex_rdst_reg == cur_rsrc1) || (ex_rdst_reg == cur_rsrc2));

    assign stall = hazard && !flush;

    // Next-state and next ID/EX contents; a bubble is the all-zero default
    always_comb begin
        state_next        = state_reg;
        hold_opcode_next  = hold_opcode_reg;
        hold_rdst_next    = hold_rdst_reg;
        hold_rsrc1_next   = hold_rsrc1_reg;
        hold_rsrc2_next   = hold_rsrc2_reg;
        hold_pc_next      = hold_pc_reg;
        ex_valid_next     = 1'b0;
        ex_opcode_next    = '0;
        ex_rdst_next      = '0;
        ex_rsrc1_next     = '0;
        ex_rsrc2_next     = '0;
        ex_rs1_data_next  = '0;
        ex_rs2_data_next  = '0;
        ex_imm_next       = '0;
        ex_pc_next        = '0;
        ex_reg_write_next = 1'b0;
        ex_mem_read_next  = 1'b0;
        ex_mem_write_next = 1'b0;

        if (flush) begin
            // Squash, dropping any half-assembled instruction
            state_next = S_OP;
        end else if (hazard) begin
            // Bubble and hold; fetch re-presents the same word next cycle
            state_next = state_reg;
        end else if (state_reg == S_IMM) begin
            ex_valid_next     = 1'b1;
            ex_opcode_next    = hold_opcode_reg;
            ex_rdst_next      = hold_rdst_reg;
            ex_rsrc1_next     = hold_rsrc1_reg;
            ex_rsrc2_next     = hold_rsrc2_reg;
            ex_rs1_data_next  = rd_data_a;
            ex_rs2_data_next  = rd_data_b;
            ex_imm_next       = DATA_W'(instruction_r);
            ex_pc_next        = hold_pc_reg;
            ex_reg_write_next = hold_ctrl.reg_write;
            ex_mem_read_next  = hold_ctrl.mem_read;
            ex_mem_write_next = hold_ctrl.mem_write;
            state_next        = S_OP;
        end else if (is_two_word(cur_opcode)) begin
            hold_opcode_next = cur_opcode;
            hold_rdst_next   = cur_rdst;
            hold_rsrc1_next  = cur_rsrc1;
            hold_rsrc2_next  = cur_rsrc2;
            hold_pc_next     = pc_plus_one_r;
            state_next       = S_IMM;
        end else begin
            ex_valid_next     = (cur_opcode != OP_NOP);
            ex_opcode_next    = cur_opcode;
            ex_rdst_next      = cur_rdst;
            ex_rsrc1_next     = cur_rsrc1;
            ex_rsrc2_next     = cur_rsrc2;
            ex_rs1_data_next  = rd_data_a;
            ex_rs2_data_next  = rd_data_b;
            ex_pc_next        = pc_plus_one_r;
            ex_reg_write_next = cur_ctrl.reg_write;
            ex_mem_read_next  = cur_ctrl.mem_read;
            ex_mem_write_next = cur_ctrl.mem_write;
        end
    end

    // State, holding and ID/EX registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_OP;
            hold_opcode_reg  <= '0;
            hold_rdst_reg    <= '0;
            hold_rsrc1_reg   <= '0;
            hold_rsrc2_reg   <= '0;
            hold_pc_reg      <= '0;
            ex_valid_reg     <= 1'b0;
            ex_opcode_reg    <= '0;
            ex_rdst_reg      <= '0;
            ex_rsrc1_reg     <= '0;
            ex_rsrc2_reg     <= '0;
            ex_rs1_data_reg  <= '0;
            ex_rs2_data_reg  <= '0;
            ex_imm_reg       <= '0;
            ex_pc_reg        <= '0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            ex_mem_write_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            hold_opcode_reg  <= hold_opcode_next;
            hold_rdst_reg    <= hold_rdst_next;
            hold_rsrc1_reg   <= hold_rsrc1_next;
            hold_rsrc2_reg   <= hold_rsrc2_next;
            hold_pc_reg      <= hold_pc_next;
            ex_valid_reg     <= ex_valid_next;
            ex_opcode_reg    <= ex_opcode_next;
            ex_rdst_reg      <= ex_rdst_next;
            ex_rsrc1_reg     <= ex_rsrc1_next;
            ex_rsrc2_reg     <= ex_rsrc2_next;
            ex_rs1_data_reg  <= ex_rs1_data_next;
            ex_rs2_data_reg  <= ex_rs2_data_next;
            ex_imm_reg       <= ex_imm_next;
            ex_pc_reg        <= ex_pc_next;
            ex_reg_write_reg <= ex_reg_write_next;
            ex_mem_read_reg  <= ex_mem_read_next;
            ex_mem_write_reg <= ex_mem_write_next;
        end
    end

    assign id_ex_valid       = ex_valid_reg;
    assign id_ex_opcode      = ex_opcode_reg;
    assign id_ex_rdst        = ex_rdst_reg;
    assign id_ex_rsrc1       = ex_rsrc1_reg;
    assign id_ex_rsrc2       = ex_rsrc2_reg;
    assign id_ex_rs1_data    = ex_rs1_data_reg;
    assign id_ex_rs2_data    = ex_rs2_data_reg;
    assign id_ex_imm         = ex_imm_reg;
    assign id_ex_pc_plus_one = ex_pc_reg;
    assign id_ex_reg_write   = ex_reg_write_reg;
    assign id_ex_mem_read    = ex_mem_read_reg;
    assign id_ex_mem_write   = ex_mem_write_reg;

endmodule
